iot_packet_receiver: RTL and testbench

UART receiver and packet deframer that consumes the serial_tx stream produced by iot_sensor_controller. It recovers 8N1 bytes, parses sensor packets, verifies the checksum and presents decoded records on a valid/ready interface. It sits downstream of the controller, on the gateway or host-bridge side and in system-level benches.

---
 rtl/iot_packet_receiver.sv | 199 +++++++++++++++++++
 tb/tb_iot_packet_receiver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_packet_receiver.sv
// UART 8N1 receiver plus sensor-packet deframer (AA type len payload csum).
// Decoded records leave on a valid/ready port; errors are one-cycle pulses.
module iot_packet_receiver #(
  parameter int         BAUD_DIV       = 868,
  parameter int         TIMEOUT_CYCLES = 20*BAUD_DIV,
  parameter logic [7:0] HDR_BYTE       = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_rx,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [7:0]  pkt_type,
  output logic [2:0]  pkt_len,
  output logic [31:0] pkt_payload,
  output logic        csum_err,
  output logic        frame_err,
  output logic        fmt_err,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {P_HDR, P_TYPE, P_LEN, P_DATA, P_CSUM} p_st_t;
  typedef struct packed {
    logic [7:0]  typ;
    logic [2:0]  len;
    logic [31:0] pay;
  } pkt_t;

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV/2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  // ---------------- synchronizer ----------------
  logic [1:0] sync_q;
  logic       rx_s, rx_prev;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], serial_rx};
      rx_prev <= rx_s;
    end
  end

  // ---------------- UART RX ----------------
  rx_st_t          rx_st, rx_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg, rx_byte;
  logic            byte_done, rx_tick;

  // Start bit is resampled at mid-bit; every later sample is one full bit on.
  assign rx_tick = (rx_st == R_START) ? (cnt == C_HALF) : (cnt == C_LAST);

  always_comb begin
    rx_nxt = rx_st;
    unique case (rx_st)
      R_IDLE:  if (rx_prev && !rx_s)           rx_nxt = R_START;
      R_START: if (rx_tick)                    rx_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tick && bit_idx == 3'd7) rx_nxt = R_STOP;
      R_STOP:  if (rx_tick)                    rx_nxt = R_IDLE;
      default:                                 rx_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st     <= R_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_st     <= rx_nxt;
      cnt       <= (rx_st == R_IDLE || rx_tick) ? '0 : cnt + 1'b1;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_st)
        R_START: bit_idx <= '0;
        R_DATA: if (rx_tick) begin
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        R_STOP: if (rx_tick) begin
          byte_done <= rx_s;
          frame_err <= !rx_s;
          rx_byte   <= shreg;
        end
        default: ;
      endcase
    end
  end

  // ---------------- packet parser ----------------
  p_st_t         p_st, p_nxt;
  pkt_t          asm_q, out_q;
  logic [7:0]    xsum;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;
  logic          timeout, good_c, csum_c, fmt_c, len_ok, last_data, parse;

  assign timeout   = (p_st != P_HDR) && (tcnt == T_LAST);
  assign len_ok    = (rx_byte != 8'd0) && (rx_byte <= 8'd4);
  assign last_data = ({1'b0, idx} == asm_q.len - 3'd1);
  assign parse     = byte_done && !frame_err && !timeout;

  always_comb begin
    p_nxt  = p_st;
    good_c = 1'b0;
    csum_c = 1'b0;
    fmt_c  = 1'b0;
    if (frame_err) begin
      p_nxt = P_HDR;
    end else if (timeout) begin
      p_nxt = P_HDR;
      fmt_c = 1'b1;
    end else if (byte_done) begin
      unique case (p_st)
        P_HDR:  if (rx_byte == HDR_BYTE) p_nxt = P_TYPE;
        P_TYPE: p_nxt = P_LEN;
        P_LEN: begin
          p_nxt = len_ok ? P_DATA : P_HDR;
          fmt_c = !len_ok;
        end
        P_DATA: if (last_data) p_nxt = P_CSUM;
        P_CSUM: begin
          p_nxt  = P_HDR;
          good_c = (rx_byte == xsum);
          csum_c = (rx_byte != xsum);
        end
        default: p_nxt = P_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_st      <= P_HDR;
      tcnt      <= '0;
      asm_q     <= '0;
      xsum      <= '0;
      idx       <= '0;
      out_q     <= '0;
      pkt_valid <= 1'b0;
      csum_err  <= 1'b0;
      fmt_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      p_st <= p_nxt;
      tcnt <= (p_st == P_HDR || byte_done || timeout) ? '0 : tcnt + 1'b1;
      if (parse) begin
        unique case (p_st)
          P_HDR:  if (rx_byte == HDR_BYTE) asm_q.pay <= '0;
          P_TYPE: begin
            asm_q.typ <= rx_byte;
            xsum      <= rx_byte;
          end
          P_LEN: begin
            asm_q.len <= rx_byte[2:0];
            xsum      <= xsum ^ rx_byte;
            idx       <= '0;
          end
          P_DATA: begin
            asm_q.pay[{idx, 3'b000} +: 8] <= rx_byte;
            xsum <= xsum ^ rx_byte;
            idx  <= idx + 2'd1;
          end
          default: ;
        endcase
      end
      csum_err <= csum_c;
      fmt_err  <= fmt_c;
      // A held, unaccepted record wins; the newer packet is the one dropped.
      overflow <= good_c && pkt_valid && !pkt_ready;
      if (good_c && (!pkt_valid || pkt_ready)) begin
        pkt_valid <= 1'b1;
        out_q     <= asm_q;
      end else if (pkt_ready) begin
        pkt_valid <= 1'b0;
      end
    end
  end

  assign pkt_type    = out_q.typ;
  assign pkt_len     = out_q.len;
  assign pkt_payload = out_q.pay;
  assign busy        = (p_st != P_HDR) || (rx_st != R_IDLE);

endmodule

// File: tb/tb_iot_packet_receiver.sv
// Directed bench for iot_packet_receiver: byte-level packet model + per-cycle output monitor.
module tb_iot_packet_receiver;
  localparam int BD = 16;
  localparam int TO = 20*BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serial_rx = 1'b1;
  logic        pkt_ready = 1'b1;
  logic        pkt_valid, csum_err, frame_err, fmt_err, overflow, busy;
  logic [7:0]  pkt_type;
  logic [2:0]  pkt_len;
  logic [31:0] pkt_payload;

  iot_packet_receiver #(.BAUD_DIV(BD), .TIMEOUT_CYCLES(TO), .HDR_BYTE(8'hAA)) dut (
    .clk(clk), .rst_n(rst_n), .serial_rx(serial_rx),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_type(pkt_type), .pkt_len(pkt_len), .pkt_payload(pkt_payload),
    .csum_err(csum_err), .frame_err(frame_err), .fmt_err(fmt_err),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [2:0]  l;
    logic [31:0] p;
  } rec_t;

  int total = 0, bad = 0;
  rec_t expq[$];
  rec_t cur;
  bit   have_cur = 0;
  int exp_csum = 0, exp_fmt = 0, exp_frame = 0, exp_ovf = 0;
  int act_csum = 0, act_fmt = 0, act_frame = 0, act_ovf = 0;
  int npub = 0;
  logic [7:0]  last_t = '0;
  logic [2:0]  last_l = '0;
  logic [31:0] last_p = '0;
  // model state: 0 hdr, 1 type, 2 len, 3 data, 4 csum
  int m_st = 0, m_len = 0, m_idx = 0;
  logic [7:0]  m_type = '0;
  logic [31:0] m_pay = '0;
  bit m_held = 0;
  logic [7:0] seq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [7:0] x;
    rec_t r;
    if (!ok) begin
      exp_frame++;
      m_st = 0;
      return;
    end
    case (m_st)
      0: if (b == 8'hAA) m_st = 1;
      1: begin m_type = b; m_pay = '0; m_st = 2; end
      2: if (b >= 8'd1 && b <= 8'd4) begin
           m_len = int'(b); m_idx = 0; m_st = 3;
         end else begin
           exp_fmt++; m_st = 0;
         end
      3: begin
           m_pay[8*m_idx +: 8] = b;
           m_idx++;
           if (m_idx == m_len) m_st = 4;
         end
      default: begin
        x = m_type ^ 8'(m_len);
        for (int i = 0; i < m_len; i++) x ^= m_pay[8*i +: 8];
        if (x != b) exp_csum++;
        else if (m_held && !pkt_ready) exp_ovf++;
        else begin
          r.t = m_type; r.l = 3'(m_len); r.p = m_pay;
          expq.push_back(r);
          m_held = !pkt_ready;
        end
        m_st = 0;
      end
    endcase
  endtask

  task automatic model_idle(input int cycles);
    if (m_st != 0 && cycles > TO) begin
      exp_fmt++;
      m_st = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    serial_rx = 1'b0;
    wait_clk(BD);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      wait_clk(BD);
    end
    serial_rx = ok;
    wait_clk(BD);
    if (!ok) begin
      serial_rx = 1'b1;
      wait_clk(2*BD);
    end
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i], 1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_csum_cnt"},  act_csum,     exp_csum);
    check({tag, "_fmt_cnt"},   act_fmt,      exp_fmt);
    check({tag, "_frame_cnt"}, act_frame,    exp_frame);
    check({tag, "_ovf_cnt"},   act_ovf,      exp_ovf);
    check({tag, "_pending"},   expq.size(),  0);
  endtask

  task automatic check_reset_outs();
    check("rst_valid",   pkt_valid,   0);
    check("rst_type",    pkt_type,    0);
    check("rst_len",     pkt_len,     0);
    check("rst_payload", pkt_payload, 0);
    check("rst_errs",    {csum_err, frame_err, fmt_err, overflow}, 0);
    check("rst_busy",    busy,        0);
  endtask

  // Output monitor: error pulse counting and per-cycle record comparison.
  initial begin
    bit pv, phs;
    pv = 0;
    phs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; phs = 0; have_cur = 0;
      end else begin
        if (csum_err)  act_csum++;
        if (fmt_err)   act_fmt++;
        if (frame_err) act_frame++;
        if (overflow)  act_ovf++;
        if (pkt_valid && (!pv || phs)) begin
          check("pub_expected", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            cur = expq.pop_front();
            have_cur = 1;
          end
          npub++;
          last_t = pkt_type; last_l = pkt_len; last_p = pkt_payload;
        end
        if (pkt_valid && have_cur) begin
          check("rec_type",    pkt_type,    cur.t);
          check("rec_len",     pkt_len,     cur.l);
          check("rec_payload", pkt_payload, cur.p);
        end
        pv  = pkt_valid;
        phs = pkt_valid && pkt_ready;
      end
    end
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clk(3);
    check_reset_outs();
    rst_n = 1'b1;
    wait_clk(5);

    // good packet, consumer ready
    pkt_ready = 1'b1;
    seq = '{8'hAA, 8'h01, 8'h02, 8'h19, 8'h00, 8'h1A};
    send_seq();
    wait_clk(20);
    check_counts("s1");
    check("s1_npub", npub, 1);
    check("s1_type", last_t, 8'h01);
    check("s1_len",  last_l, 3'd2);
    check("s1_pay",  last_p, 32'h19);
    check("s1_idle_busy", busy, 0);
    check("s1_valid_gone", pkt_valid, 0);

    // consumer stalled: second packet overflows, first is held
    pkt_ready = 1'b0;
    seq = '{8'hAA, 8'h03, 8'h02, 8'h42, 8'h01, 8'h42,
            8'hAA, 8'h02, 8'h01, 8'h32, 8'h31};
    send_seq();
    wait_clk(20);
    check_counts("s2");
    check("s2_valid_held", pkt_valid, 1);
    check("s2_type", pkt_type, 8'h03);
    check("s2_pay",  pkt_payload, 32'h142);
    pkt_ready = 1'b1;
    m_held = 0;
    wait_clk(1);
    check("s2_valid_drop", pkt_valid, 0);
    wait_clk(5);

    // bad checksum then good packet
    seq = '{8'hAA, 8'h02, 8'h01, 8'h32, 8'h30, 8'hAA, 8'h02, 8'h01, 8'h32, 8'h31};
    send_seq();
    wait_clk(20);
    check_counts("s3");
    check("s3_npub", npub, 3);
    check("s3_type", last_t, 8'h02);
    check("s3_pay",  last_p, 32'h32);

    // framing error mid-packet, resync, then a short glitch
    seq = '{8'hAA, 8'h01, 8'h02};
    send_seq();
    send_byte(8'h19, 1'b0);
    seq = '{8'hAA, 8'h01, 8'h02, 8'h19, 8'h00, 8'h1A};
    send_seq();
    wait_clk(10);
    serial_rx = 1'b0;
    wait_clk(4);
    serial_rx = 1'b1;
    wait_clk(40);
    check_counts("s4");
    check("s4_npub", npub, 4);
    check("s4_pay",  last_p, 32'h19);
    check("s4_busy", busy, 0);

    // bad length, then inter-byte timeout
    seq = '{8'hAA, 8'h01, 8'h05};
    send_seq();
    wait_clk(20);
    check_counts("s5a");
    seq = '{8'hAA, 8'h01, 8'h02, 8'h19};
    send_seq();
    wait_clk(10);
    check("s5_busy_wait", busy, 1);
    model_idle(400);
    wait_clk(390);
    check_counts("s5b");
    check("s5_busy_end", busy, 0);

    // reset in the middle of the payload, then resend
    seq = '{8'hAA, 8'h01, 8'h02};
    send_seq();
    serial_rx = 1'b0;
    wait_clk(BD);
    for (int i = 0; i < 4; i++) begin
      serial_rx = i[0];
      wait_clk(BD);
    end
    rst_n = 1'b0;
    serial_rx = 1'b1;
    m_st = 0;
    m_held = 0;
    wait_clk(3);
    check_reset_outs();
    rst_n = 1'b1;
    wait_clk(5);
    seq = '{8'hAA, 8'h01, 8'h02, 8'h19, 8'h00, 8'h1A};
    send_seq();
    wait_clk(20);
    check_counts("s6");
    check("s6_npub", npub, 5);
    check("s6_type", last_t, 8'h01);
    check("s6_pay",  last_p, 32'h19);

    check("tot_csum",  act_csum,  1);
    check("tot_fmt",   act_fmt,   2);
    check("tot_frame", act_frame, 1);
    check("tot_ovf",   act_ovf,   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
